instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 141 ++++++++++++++
 tb/tb_instr_fetch.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem request, 2-entry {pc, instr} buffer, redirect flush.
// Optional macro FETCH_PERF_CNT_EN adds a delivered-instruction counter on fetch_count.
module instr_fetch (
  input  logic        clk,
  input  logic        reset1_n,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic [31:0] fetch_count
);

  // Handshakes: a transfer happens on a rising edge where the producer's valid/req and the
  // consumer's ready are both 1; valid/req never depend on ready. imem_rvalid has no ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] req_pc;
  logic [63:0] fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  fifo_count;
  logic        accept;
  logic        push;
  logic        pop;

  // The outstanding request is not counted separately: requests only leave IDLE.
  assign imem_req  = reset1_n && (state_q == IDLE) && !redirect && (fifo_count < 2'd2);
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ready;
  assign push      = (state_q == WAIT) && imem_rvalid && !redirect;
  assign pop       = if_valid && id_ready;

  assign if_valid  = (fifo_count != 2'd0);
  assign if_pc     = fifo_mem[rd_ptr][63:32];
  assign if_instr  = fifo_mem[rd_ptr][31:0];

  always_comb begin
    next_pc = pc;
    if (redirect) begin
      next_pc = redirect_pc;
    end else if (accept) begin
      next_pc = pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset1_n) begin
    if (!reset1_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = WAIT;
      end
      WAIT: begin
        // A response arriving with a redirect ends the request but is discarded.
        if (imem_rvalid) begin
          state_d = IDLE;
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset1_n) begin
    if (!reset1_n) begin
      req_pc <= '0;
    end else if (accept) begin
      req_pc <= pc;
    end
  end

  always_ff @(posedge clk or negedge reset1_n) begin
    if (!reset1_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else if (redirect) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {req_pc, imem_rdata};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk or negedge reset1_n) begin
    if (!reset1_n) begin
      fetch_count_q <= '0;
    end else if (pop) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: upstream pc register model, latency-programmable memory
// responder, expected-queue scoreboard with a decoupled decode-side monitor.
module tb_instr_fetch;

  logic        clk;
  logic        reset1_n = 1'b1;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic [31:0] fetch_count;

  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          mem_lat  = 1;

`ifdef FETCH_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  instr_fetch dut (
    .clk        (clk),
    .reset1_n   (reset1_n),
    .pc         (pc),
    .next_pc    (next_pc),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .id_ready   (id_ready),
    .fetch_count(fetch_count)
  );

  // clock / reset / upstream program counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge reset1_n) begin
    if (!reset1_n) pc <= 32'h0;
    else           pc <= next_pc;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic expect_instr(input logic [31:0] addr, input logic [31:0] instr);
    exp_q.push_back({addr, instr});
  endtask

  // memory responder: returns 0xA0000000 + addr, mem_lat cycles after acceptance
  initial begin
    logic        pend;
    int          cnt;
    logic [31:0] addr;
    pend        = 1'b0;
    cnt         = 0;
    addr        = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0BAD_0BAD;
    forever begin
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0BAD_0BAD;
      if (pend) begin
        if (cnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = 32'hA000_0000 + addr;
          pend        = 1'b0;
        end else begin
          cnt--;
        end
      end
      @(negedge clk);
      if (reset1_n && imem_req && imem_ready && !pend) begin
        pend = 1'b1;
        cnt  = mem_lat;
        addr = imem_addr;
      end
    end
  end

  // scoreboard monitor: decode side
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (reset1_n && if_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got if_pc=%h if_instr=%h expected no instruction", if_pc, if_instr);
        end else begin
          e = exp_q.pop_front();
          check("mon_if_pc", if_pc, e[63:32]);
          check("mon_if_instr", if_instr, e[31:0]);
        end
      end
    end
  end

  initial begin
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ready  = 1'b0;
    id_ready    = 1'b0;
    #1 reset1_n = 1'b0;
    repeat (3) next_cycle();
    settle();
    check("rst_if_valid", {31'b0, if_valid}, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_fetch_count", fetch_count, 32'h0);
    check("rst_imem_req", {31'b0, imem_req}, 32'h0);

    // basic fetch: one instruction per two cycles, next_pc +4 per accept
    next_cycle();
    reset1_n   = 1'b1;
    imem_ready = 1'b1;
    id_ready   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_instr(32'(4 * i), 32'hA000_0000 + 32'(4 * i));
      settle();
      check("basic_req", {31'b0, imem_req}, 32'h1);
      check("basic_addr", imem_addr, 32'(4 * i));
      check("basic_next_pc_acc", next_pc, 32'(4 * i + 4));
      next_cycle();
      settle();
      check("basic_wait_req", {31'b0, imem_req}, 32'h0);
      check("basic_no_bypass", {31'b0, if_valid}, 32'h0);
      check("basic_next_pc_hold", next_pc, 32'(4 * i + 4));
      next_cycle();
    end
    imem_ready = 1'b0;

    // backpressure: two buffered, then no further requests
    next_cycle();
    id_ready   = 1'b0;
    imem_ready = 1'b1;
    expect_instr(32'h0C, 32'hA000_000C);
    expect_instr(32'h10, 32'hA000_0010);
    for (int k = 2; k <= 6; k++) begin
      next_cycle();
      if (k >= 5) begin
        settle();
        check("bp_req_blocked", {31'b0, imem_req}, 32'h0);
        check("bp_if_valid", {31'b0, if_valid}, 32'h1);
        check("bp_head_pc", if_pc, 32'h0C);
      end
    end
    next_cycle();
    imem_ready = 1'b0;
    id_ready   = 1'b1;
    next_cycle();

    // push and pop in the same cycle
    next_cycle();
    id_ready   = 1'b0;
    imem_ready = 1'b1;
    expect_instr(32'h14, 32'hA000_0014);
    expect_instr(32'h18, 32'hA000_0018);
    next_cycle();
    next_cycle();
    next_cycle();
    id_ready = 1'b1;
    next_cycle();
    imem_ready = 1'b0;
    settle();
    check("pp_if_valid", {31'b0, if_valid}, 32'h1);
    check("pp_if_pc", if_pc, 32'h18);
    check("pp_if_instr", if_instr, 32'hA000_0018);

    // redirect while waiting; late response discarded
    next_cycle();
    mem_lat    = 2;
    imem_ready = 1'b1;
    next_cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    settle();
    check("rw_next_pc", next_pc, 32'h100);
    check("rw_req", {31'b0, imem_req}, 32'h0);
    next_cycle();
    redirect = 1'b0;
    mem_lat  = 1;
    settle();
    check("rw_drop_if_valid", {31'b0, if_valid}, 32'h0);
    check("rw_drop_req", {31'b0, imem_req}, 32'h0);
    next_cycle();
    expect_instr(32'h100, 32'hA000_0100);
    settle();
    check("rw_resume_req", {31'b0, imem_req}, 32'h1);
    check("rw_resume_addr", imem_addr, 32'h100);
    next_cycle();
    next_cycle();
    imem_ready = 1'b0;

    // redirect coinciding with rvalid
    next_cycle();
    imem_ready = 1'b1;
    next_cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    imem_ready  = 1'b0;
    settle();
    check("rv_next_pc", next_pc, 32'h200);
    next_cycle();
    redirect   = 1'b0;
    imem_ready = 1'b1;
    expect_instr(32'h200, 32'hA000_0200);
    settle();
    check("rv_if_valid", {31'b0, if_valid}, 32'h0);
    check("rv_req", {31'b0, imem_req}, 32'h1);
    check("rv_addr", imem_addr, 32'h200);
    next_cycle();
    next_cycle();
    imem_ready = 1'b0;

    // flush a full buffer, then fetch at the wrap address
    next_cycle();
    id_ready   = 1'b0;
    imem_ready = 1'b1;
    repeat (4) next_cycle();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    imem_ready  = 1'b0;
    settle();
    check("fl_full_if_valid", {31'b0, if_valid}, 32'h1);
    check("fl_fetch_count", fetch_count, CNT_EN ? 32'd9 : 32'd0);
    next_cycle();
    redirect   = 1'b0;
    imem_ready = 1'b1;
    settle();
    check("fl_flushed", {31'b0, if_valid}, 32'h0);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap_next_pc", next_pc, 32'h0);
    next_cycle();
    mem_lat = 3;
    next_cycle();
    settle();
    check("wrap_addr0", imem_addr, 32'h0);
    check("wrap_head_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap_head_instr", if_instr, 32'h9FFF_FFFC);

    // reset while a request is outstanding and the buffer holds data
    next_cycle();
    reset1_n   = 1'b0;
    imem_ready = 1'b0;
    settle();
    check("ar_if_valid", {31'b0, if_valid}, 32'h0);
    check("ar_if_pc", if_pc, 32'h0);
    check("ar_if_instr", if_instr, 32'h0);
    check("ar_imem_req", {31'b0, imem_req}, 32'h0);
    check("ar_fetch_count", fetch_count, 32'h0);
    next_cycle();
    next_cycle();
    reset1_n = 1'b1;
    next_cycle();
    settle();
    check("late_rvalid_ignored", {31'b0, if_valid}, 32'h0);
    check("post_rst_req", {31'b0, imem_req}, 32'h1);
    check("post_rst_addr", imem_addr, 32'h0);

    // ten deliveries for the counter
    imem_ready = 1'b1;
    id_ready   = 1'b1;
    mem_lat    = 1;
    for (int i = 0; i < 10; i++) begin
      expect_instr(32'(4 * i), 32'hA000_0000 + 32'(4 * i));
      next_cycle();
      next_cycle();
    end
    imem_ready = 1'b0;
    next_cycle();
    settle();
    check("cnt_after_10", fetch_count, CNT_EN ? 32'd10 : 32'd0);

    repeat (3) next_cycle();
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
